// File: rtl/pkt_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// pkt_buf_ctrl_if
// Groups the ingress beat handshake, the egress word request and the packet
// buffer control/status signals of pkt_buf_ctrl.
//
// Parameters:
//   ADDR_WIDTH  buffer address width (pointers carry one extra wrap bit)
//   DROP_CNT_W  width of the dropped-packet counter
//
// Signals (direction as seen by the controller):
//   wr_valid_i, wr_sop_i, wr_eop_i, wr_err_i   ingress beat qualifiers (in)
//   wr_ready_o                                  ingress accept (out)
//   rd_req_i                                    egress word request (in)
//   rd_valid_o                                  buffer read data valid (out)
//   buf_wr_en_o, buf_wr_addr_o                  buffer write port (out)
//   buf_rd_en_o, buf_rd_addr_o                  buffer read port (out)
//   buf_full_o, buf_empty_o, words_avail_o      occupancy status (out)
//   drop_cnt_o                                  dropped-packet count (out)
//
// Modports: master = stream/egress side, slave = controller.
// ---------------------------------------------------------------------------
interface pkt_buf_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DROP_CNT_W = 16
);
  logic                  wr_valid_i;
  logic                  wr_sop_i;
  logic                  wr_eop_i;
  logic                  wr_err_i;
  logic                  wr_ready_o;
  logic                  rd_req_i;
  logic                  rd_valid_o;
  logic                  buf_wr_en_o;
  logic [ADDR_WIDTH:0]   buf_wr_addr_o;
  logic                  buf_rd_en_o;
  logic [ADDR_WIDTH:0]   buf_rd_addr_o;
  logic                  buf_full_o;
  logic                  buf_empty_o;
  logic [ADDR_WIDTH:0]   words_avail_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;

  modport master (
    output wr_valid_i, wr_sop_i, wr_eop_i, wr_err_i, rd_req_i,
    input  wr_ready_o, rd_valid_o, buf_wr_en_o, buf_wr_addr_o, buf_rd_en_o,
           buf_rd_addr_o, buf_full_o, buf_empty_o, words_avail_o, drop_cnt_o
  );

  modport slave (
    input  wr_valid_i, wr_sop_i, wr_eop_i, wr_err_i, rd_req_i,
    output wr_ready_o, rd_valid_o, buf_wr_en_o, buf_wr_addr_o, buf_rd_en_o,
           buf_rd_addr_o, buf_full_o, buf_empty_o, words_avail_o, drop_cnt_o
  );
endinterface

// File: rtl/pkt_buf_ctrl.sv
// ---------------------------------------------------------------------------
// pkt_buf_ctrl
// Packet-level controller for a 2**ADDR_WIDTH word packet buffer. Packets are
// written speculatively at wr_ptr and only become readable once their EOP
// beat moves commit_ptr. A packet that grows to fill the whole buffer is
// rewound and the rest of it discarded; a new SOP inside an open packet drops
// the partial packet and restarts at commit_ptr.
//
// Optional feature macro: PKT_BUF_CTRL_ERR_DROP_EN
//   defined   : an EOP beat with wr_err_i=1 drops the packet (not written)
//   undefined : wr_err_i is ignored
//
// Ports:
//   pkt_buf_ctrl_clk  single clock
//   pkt_buf_ctrl_rst  synchronous active-high reset
//   bus               pkt_buf_ctrl_if.slave (ingress, egress, buffer control)
// ---------------------------------------------------------------------------
module pkt_buf_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16384,
  parameter int DROP_CNT_W = 16
) (
  input logic           pkt_buf_ctrl_clk,
  input logic           pkt_buf_ctrl_rst,
  pkt_buf_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PKT  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         commit_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_nxt_s;
  logic [PW-1:0]         commit_ptr_nxt_s;
  logic [PW-1:0]         wr_base_s;
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  logic [1:0]            drop_add_s;
  logic                  rd_valid_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  ready_s;
  logic                  accept_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  start_s;
  logic                  cont_s;
  logic                  err_drop_s;

  // Saturating add for the drop counter (a restart plus an errored EOP can
  // drop two packets in one cycle).
  function automatic logic [DROP_CNT_W-1:0] sat_add(
    input logic [DROP_CNT_W-1:0] cnt,
    input logic [1:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_CNT_W-1){1'b0}}, inc};
    if (sum[DROP_CNT_W]) begin
      sat_add = DROP_MAX;
    end else begin
      sat_add = sum[DROP_CNT_W-1:0];
    end
  endfunction

  // Occupancy is decoded from registered pointers only, so a same-cycle read
  // never unblocks a write and a same-cycle commit never enables a read.
  assign full_s   = (wr_ptr_r - rd_ptr_r) == PTR_DEPTH;
  assign empty_s  = (rd_ptr_r == commit_ptr_r);
  assign ready_s  = (state_r == DISCARD) || !full_s;
  assign accept_s = bus.wr_valid_i && ready_s;
  assign rd_en_s  = bus.rd_req_i && !empty_s;

`ifdef PKT_BUF_CTRL_ERR_DROP_EN
  assign err_drop_s = bus.wr_eop_i && bus.wr_err_i;
`else
  logic unused_err_s;
  assign unused_err_s = bus.wr_err_i;
  assign err_drop_s   = 1'b0;
`endif

  // Write FSM next-state, pointer updates and buffer write enable.
  always_comb begin
    state_nxt_s      = state_r;
    wr_ptr_nxt_s     = wr_ptr_r;
    commit_ptr_nxt_s = commit_ptr_r;
    wr_base_s        = wr_ptr_r;
    drop_add_s       = 2'd0;
    start_s          = 1'b0;
    cont_s           = 1'b0;
    wr_en_s          = 1'b0;

    case (state_r)
      IDLE, DISCARD: begin
        if (accept_s && bus.wr_sop_i) begin
          start_s = 1'b1;
        end else if (accept_s && bus.wr_eop_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      WR_PKT: begin
        if (full_s && empty_s) begin
          // Open packet alone fills the buffer: it can never commit.
          wr_ptr_nxt_s = commit_ptr_r;
          drop_add_s   = 2'd1;
          state_nxt_s  = DISCARD;
        end else if (accept_s && bus.wr_sop_i) begin
          // Restart: abandon the partial packet, reuse its space.
          wr_base_s  = commit_ptr_r;
          drop_add_s = 2'd1;
          start_s    = 1'b1;
        end else if (accept_s) begin
          cont_s = 1'b1;
        end else begin
          state_nxt_s = WR_PKT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (start_s || cont_s) begin
      if (err_drop_s) begin
        wr_en_s      = 1'b0;
        wr_ptr_nxt_s = commit_ptr_r;
        drop_add_s   = drop_add_s + 2'd1;
        state_nxt_s  = IDLE;
      end else if (bus.wr_eop_i) begin
        wr_en_s          = 1'b1;
        wr_ptr_nxt_s     = wr_base_s + PTR_ONE;
        commit_ptr_nxt_s = wr_base_s + PTR_ONE;
        state_nxt_s      = IDLE;
      end else begin
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = wr_base_s + PTR_ONE;
        state_nxt_s  = WR_PKT;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // State, pointer, drop counter and read-valid registers.
  always_ff @(posedge pkt_buf_ctrl_clk) begin
    if (pkt_buf_ctrl_rst) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {PW{1'b0}};
      commit_ptr_r <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      drop_cnt_r   <= {DROP_CNT_W{1'b0}};
      rd_valid_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      commit_ptr_r <= commit_ptr_nxt_s;
      rd_ptr_r     <= rd_en_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      drop_cnt_r   <= sat_add(drop_cnt_r, drop_add_s);
      rd_valid_r   <= rd_en_s;
    end
  end

  assign bus.wr_ready_o    = ready_s;
  assign bus.buf_wr_en_o   = wr_en_s;
  assign bus.buf_wr_addr_o = wr_base_s;
  assign bus.buf_rd_en_o   = rd_en_s;
  assign bus.buf_rd_addr_o = rd_ptr_r;
  assign bus.buf_full_o    = full_s;
  assign bus.buf_empty_o   = empty_s;
  assign bus.words_avail_o = commit_ptr_r - rd_ptr_r;
  assign bus.drop_cnt_o    = drop_cnt_r;
  assign bus.rd_valid_o    = rd_valid_r;
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pkt_buf_ctrl
// Self-checking bench for pkt_buf_ctrl with a small buffer (DEPTH=32).
// The reference model tracks committed words, open-packet length and read
// count as plain integers; pointer values are those counts modulo 2*DEPTH.
// ---------------------------------------------------------------------------
module tb_pkt_buf_ctrl;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int DW    = 16;
  localparam int PMOD  = 2 * DEPTH;
  typedef logic [AW:0] ptr_t;

`ifdef PKT_BUF_CTRL_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_buf_ctrl_if #(.ADDR_WIDTH(AW), .DROP_CNT_W(DW)) bus ();

  pkt_buf_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .pkt_buf_ctrl_clk(clk),
    .pkt_buf_ctrl_rst(rst),
    .bus             (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int m_commit, m_rd, m_open, m_drops;
  bit m_in_pkt, m_disc, m_rvalid;

  // expectations for the current cycle
  bit   e_full, e_empty, e_ready, e_ovf, e_acc, e_wen, e_ren, e_rvalid;
  ptr_t e_waddr, e_raddr, e_avail;
  logic [DW-1:0] e_drops;

  // Apply inputs, wait to the falling edge and derive expected outputs.
  task automatic settle(input bit v, input bit s, input bit e, input bit er, input bit r);
    bus.wr_valid_i = v;
    bus.wr_sop_i   = s;
    bus.wr_eop_i   = e;
    bus.wr_err_i   = er;
    bus.rd_req_i   = r;
    @(negedge clk);
    e_full   = (m_commit + m_open - m_rd) == DEPTH;
    e_empty  = (m_commit == m_rd);
    e_ready  = m_disc || !e_full;
    e_ovf    = m_in_pkt && e_full && e_empty;
    e_acc    = v && e_ready;
    e_wen    = e_acc && (s || m_in_pkt) && !(ERR_DROP && e && er);
    e_waddr  = ptr_t'((e_acc && s && m_in_pkt) ? (m_commit % PMOD) : ((m_commit + m_open) % PMOD));
    e_ren    = r && !e_empty;
    e_raddr  = ptr_t'(m_rd % PMOD);
    e_avail  = ptr_t'((m_commit - m_rd) % PMOD);
    e_drops  = (m_drops > 65535) ? 16'hFFFF : DW'(m_drops);
    e_rvalid = m_rvalid;
  endtask

  // Clock edge: advance the model by the packet rules.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_commit = 0; m_rd = 0; m_open = 0; m_drops = 0;
      m_in_pkt = 1'b0; m_disc = 1'b0; m_rvalid = 1'b0;
    end else begin
      m_rvalid = e_ren;
      if (e_ren) m_rd++;
      if (e_ovf) begin
        m_open = 0; m_drops++; m_in_pkt = 1'b0; m_disc = 1'b1;
      end else if (e_acc) begin
        if (bus.wr_sop_i) begin
          if (m_in_pkt) m_drops++;
          m_open = 0; m_disc = 1'b0; m_in_pkt = 1'b1;
        end
        if (m_in_pkt) begin
          if (ERR_DROP && bus.wr_eop_i && bus.wr_err_i) begin
            m_drops++; m_open = 0; m_in_pkt = 1'b0;
          end else begin
            m_open++;
            if (bus.wr_eop_i) begin
              m_commit += m_open; m_open = 0; m_in_pkt = 1'b0;
            end
          end
        end else if (m_disc && bus.wr_eop_i) begin
          m_disc = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle(0, 0, 0, 0, 0); tick();
    settle(0, 0, 0, 0, 0); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle(0, 0, 0, 0, 1);
    n_total++; if (bus.wr_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.wr_ready_o); else n_pass++;
    n_total++; if (bus.buf_full_o !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.buf_full_o); else n_pass++;
    n_total++; if (bus.buf_empty_o !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.buf_empty_o); else n_pass++;
    n_total++; if (bus.buf_rd_en_o !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", bus.buf_rd_en_o); else n_pass++;
    n_total++; if ({bus.rd_valid_o, bus.buf_wr_en_o} !== 2'b00) $display("FAIL reset_valid_wen got=%b exp=00", {bus.rd_valid_o, bus.buf_wr_en_o}); else n_pass++;
    n_total++; if ({bus.buf_wr_addr_o, bus.buf_rd_addr_o, bus.words_avail_o} !== 18'd0) $display("FAIL reset_ptrs got=%0d/%0d/%0d exp=0/0/0", bus.buf_wr_addr_o, bus.buf_rd_addr_o, bus.words_avail_o); else n_pass++;
    n_total++; if (bus.drop_cnt_o !== 16'd0) $display("FAIL reset_drop got=%0d exp=0", bus.drop_cnt_o); else n_pass++;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    for (int b = 0; b < 4; b++) begin
      settle(1, b == 0, b == 3, 0, 0);
      n_total++; if (bus.buf_wr_en_o !== 1'b1 || bus.buf_wr_addr_o !== ptr_t'(b)) $display("FAIL basic_wr beat=%0d got en=%b addr=%0d exp en=1 addr=%0d", b, bus.buf_wr_en_o, bus.buf_wr_addr_o, b); else n_pass++;
      n_total++; if (bus.buf_empty_o !== 1'b1) $display("FAIL basic_early_empty beat=%0d got=%b exp=1", b, bus.buf_empty_o); else n_pass++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      settle(0, 0, 0, 0, 1);
      if (i == 0) begin
        n_total++; if (bus.words_avail_o !== ptr_t'(4) || bus.buf_empty_o !== 1'b0) $display("FAIL basic_commit got avail=%0d empty=%b exp avail=4 empty=0", bus.words_avail_o, bus.buf_empty_o); else n_pass++;
      end
      n_total++; if (bus.buf_rd_en_o !== 1'b1 || bus.buf_rd_addr_o !== ptr_t'(i)) $display("FAIL basic_rd i=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, bus.buf_rd_en_o, bus.buf_rd_addr_o, i); else n_pass++;
      n_total++; if (bus.rd_valid_o !== (i != 0)) $display("FAIL basic_rvalid i=%0d got=%b exp=%b", i, bus.rd_valid_o, i != 0); else n_pass++;
      tick();
    end
    settle(0, 0, 0, 0, 1);
    n_total++; if (bus.rd_valid_o !== 1'b1 || bus.buf_rd_en_o !== 1'b0) $display("FAIL basic_last got rvalid=%b rd_en=%b exp 1/0", bus.rd_valid_o, bus.buf_rd_en_o); else n_pass++;
    n_total++; if (bus.buf_empty_o !== 1'b1 || bus.buf_rd_addr_o !== ptr_t'(4)) $display("FAIL basic_drained got empty=%b rd_addr=%0d exp 1/4", bus.buf_empty_o, bus.buf_rd_addr_o); else n_pass++;
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 8; b++) begin
        settle(1, b == 0, b == 7, 0, 0);
        tick();
      end
    end
    // full: a same-cycle read must not let the SOP in
    settle(1, 1, 0, 0, 1);
    n_total++; if (bus.buf_full_o !== 1'b1 || bus.wr_ready_o !== 1'b0) $display("FAIL fill_full got full=%b ready=%b exp 1/0", bus.buf_full_o, bus.wr_ready_o); else n_pass++;
    n_total++; if (bus.buf_wr_en_o !== 1'b0 || bus.buf_rd_en_o !== 1'b1) $display("FAIL fill_same_cycle got wen=%b ren=%b exp 0/1", bus.buf_wr_en_o, bus.buf_rd_en_o); else n_pass++;
    n_total++; if (bus.buf_wr_addr_o !== 6'd32 || bus.words_avail_o !== 6'd32) $display("FAIL fill_wrap got waddr=%0d avail=%0d exp 32/32", bus.buf_wr_addr_o, bus.words_avail_o); else n_pass++;
    tick();
    settle(0, 0, 0, 0, 0);
    n_total++; if (bus.buf_full_o !== 1'b0 || bus.wr_ready_o !== 1'b1) $display("FAIL fill_unfull got full=%b ready=%b exp 0/1", bus.buf_full_o, bus.wr_ready_o); else n_pass++;
    tick();
    for (int i = 0; i < 31; i++) begin
      settle(0, 0, 0, 0, 1);
      tick();
    end
    settle(0, 0, 0, 0, 1);
    n_total++; if (bus.buf_rd_addr_o !== 6'd32 || bus.buf_empty_o !== 1'b1 || bus.buf_rd_en_o !== 1'b0) $display("FAIL fill_drain got raddr=%0d empty=%b ren=%b exp 32/1/0", bus.buf_rd_addr_o, bus.buf_empty_o, bus.buf_rd_en_o); else n_pass++;
    tick();
  endtask

  task automatic test_oversize();
    do_reset();
    for (int b = 0; b < DEPTH; b++) begin
      settle(1, b == 0, 0, 0, 0);
      tick();
    end
    settle(1, 0, 0, 0, 0);
    n_total++; if (bus.wr_ready_o !== 1'b0 || bus.buf_wr_en_o !== 1'b0) $display("FAIL ovf_stall got ready=%b wen=%b exp 0/0", bus.wr_ready_o, bus.buf_wr_en_o); else n_pass++;
    tick();
    for (int b = 0; b < 8; b++) begin
      settle(1, 0, b == 7, 0, 0);
      if (b == 0) begin
        n_total++; if (bus.drop_cnt_o !== 16'd1 || bus.buf_wr_addr_o !== 6'd0) $display("FAIL ovf_rewind got drop=%0d waddr=%0d exp 1/0", bus.drop_cnt_o, bus.buf_wr_addr_o); else n_pass++;
      end
      n_total++; if (bus.wr_ready_o !== 1'b1 || bus.buf_wr_en_o !== 1'b0) $display("FAIL ovf_discard b=%0d got ready=%b wen=%b exp 1/0", b, bus.wr_ready_o, bus.buf_wr_en_o); else n_pass++;
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      settle(1, b == 0, b == 1, 0, 0);
      n_total++; if (bus.buf_wr_en_o !== 1'b1 || bus.buf_wr_addr_o !== ptr_t'(b)) $display("FAIL ovf_next b=%0d got wen=%b addr=%0d exp 1/%0d", b, bus.buf_wr_en_o, bus.buf_wr_addr_o, b); else n_pass++;
      tick();
    end
    settle(0, 0, 0, 0, 0);
    n_total++; if (bus.words_avail_o !== 6'd2 || bus.drop_cnt_o !== 16'd1) $display("FAIL ovf_commit got avail=%0d drop=%0d exp 2/1", bus.words_avail_o, bus.drop_cnt_o); else n_pass++;
    tick();
  endtask

  task automatic test_mid_sop();
    do_reset();
    for (int b = 0; b < 3; b++) begin
      settle(1, b == 0, 0, 0, 0);
      tick();
    end
    settle(1, 1, 0, 0, 0);
    n_total++; if (bus.buf_wr_en_o !== 1'b1 || bus.buf_wr_addr_o !== 6'd0) $display("FAIL midsop_restart got wen=%b addr=%0d exp 1/0", bus.buf_wr_en_o, bus.buf_wr_addr_o); else n_pass++;
    tick();
    for (int b = 1; b < 3; b++) begin
      settle(1, 0, b == 2, 0, 0);
      n_total++; if (bus.buf_wr_addr_o !== ptr_t'(b)) $display("FAIL midsop_addr b=%0d got=%0d exp=%0d", b, bus.buf_wr_addr_o, b); else n_pass++;
      tick();
    end
    settle(0, 0, 0, 0, 0);
    n_total++; if (bus.drop_cnt_o !== 16'd1 || bus.words_avail_o !== 6'd3) $display("FAIL midsop_commit got drop=%0d avail=%0d exp 1/3", bus.drop_cnt_o, bus.words_avail_o); else n_pass++;
    tick();
  endtask

  task automatic test_err();
    ptr_t exp_avail;
    logic [DW-1:0] exp_drop;
    exp_avail = ERR_DROP ? 6'd0 : 6'd5;
    exp_drop  = ERR_DROP ? 16'd1 : 16'd0;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      settle(1, b == 0, b == 4, b == 4, 0);
      if (b == 4) begin
        n_total++; if (bus.buf_wr_en_o !== !ERR_DROP) $display("FAIL err_eop_wen got=%b exp=%b", bus.buf_wr_en_o, !ERR_DROP); else n_pass++;
      end
      tick();
    end
    settle(0, 0, 0, 0, 0);
    n_total++; if (bus.words_avail_o !== exp_avail || bus.drop_cnt_o !== exp_drop) $display("FAIL err_result got avail=%0d drop=%0d exp %0d/%0d", bus.words_avail_o, bus.drop_cnt_o, exp_avail, exp_drop); else n_pass++;
    n_total++; if (bus.buf_wr_addr_o !== exp_avail) $display("FAIL err_wrptr got=%0d exp=%0d", bus.buf_wr_addr_o, exp_avail); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    settle(1, 1, 0, 0, 0); tick();
    settle(1, 0, 0, 0, 0); tick();
    settle(1, 1, 0, 0, 0); tick();   // restart: one drop before reset
    settle(1, 0, 0, 0, 0); tick();
    rst = 1'b1;
    settle(1, 0, 0, 0, 0); tick();
    rst = 1'b0;
    settle(0, 0, 0, 0, 0);
    n_total++; if ({bus.buf_wr_addr_o, bus.buf_rd_addr_o, bus.words_avail_o} !== 18'd0) $display("FAIL rstmid_ptrs got=%0d/%0d/%0d exp=0/0/0", bus.buf_wr_addr_o, bus.buf_rd_addr_o, bus.words_avail_o); else n_pass++;
    n_total++; if (bus.buf_empty_o !== 1'b1 || bus.drop_cnt_o !== 16'd0) $display("FAIL rstmid_state got empty=%b drop=%0d exp 1/0", bus.buf_empty_o, bus.drop_cnt_o); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int gen_rem;
    int newlen;
    bit v, s, e, er, r;
    gen_rem = 0;
    newlen  = 1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      v  = ($urandom % 5) != 0;
      er = ($urandom % 4) == 0;
      r  = (c < 1200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      if (gen_rem == 0) begin
        if (($urandom % 20) == 0) begin
          s = 1'b0; e = ($urandom % 2) == 0;
        end else begin
          newlen = $urandom_range(1, 12); s = 1'b1; e = (newlen == 1);
        end
      end else if (($urandom % 25) == 0) begin
        newlen = $urandom_range(1, 12); s = 1'b1; e = (newlen == 1);
      end else begin
        s = 1'b0; e = (gen_rem == 1);
      end
      settle(v, s, e, er, r);
      n_total++; if (bus.wr_ready_o !== e_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.wr_ready_o, e_ready); else n_pass++;
      n_total++; if (bus.buf_wr_en_o !== e_wen) $display("FAIL rnd_wen c=%0d got=%b exp=%b", c, bus.buf_wr_en_o, e_wen); else n_pass++;
      n_total++; if (bus.buf_wr_addr_o !== e_waddr) $display("FAIL rnd_waddr c=%0d got=%0d exp=%0d", c, bus.buf_wr_addr_o, e_waddr); else n_pass++;
      n_total++; if (bus.buf_rd_en_o !== e_ren) $display("FAIL rnd_ren c=%0d got=%b exp=%b", c, bus.buf_rd_en_o, e_ren); else n_pass++;
      n_total++; if (bus.buf_rd_addr_o !== e_raddr) $display("FAIL rnd_raddr c=%0d got=%0d exp=%0d", c, bus.buf_rd_addr_o, e_raddr); else n_pass++;
      n_total++; if (bus.buf_full_o !== e_full) $display("FAIL rnd_full c=%0d got=%b exp=%b", c, bus.buf_full_o, e_full); else n_pass++;
      n_total++; if (bus.buf_empty_o !== e_empty) $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, bus.buf_empty_o, e_empty); else n_pass++;
      n_total++; if (bus.words_avail_o !== e_avail) $display("FAIL rnd_avail c=%0d got=%0d exp=%0d", c, bus.words_avail_o, e_avail); else n_pass++;
      n_total++; if (bus.drop_cnt_o !== e_drops) $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, bus.drop_cnt_o, e_drops); else n_pass++;
      n_total++; if (bus.rd_valid_o !== e_rvalid) $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, bus.rd_valid_o, e_rvalid); else n_pass++;
      if (v && e_ready) begin
        if (s) gen_rem = newlen - 1;
        else if (gen_rem > 0) gen_rem--;
      end
      tick();
    end
  endtask

  initial begin
    bus.wr_valid_i = 1'b0;
    bus.wr_sop_i   = 1'b0;
    bus.wr_eop_i   = 1'b0;
    bus.wr_err_i   = 1'b0;
    bus.rd_req_i   = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_oversize();
    test_mid_sop();
    test_err();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pkt_buf_ctrl.md
# pkt_buf_ctrl

Packet-level controller for the 32-bit internal packet buffer (2**ADDR_WIDTH words). It generates the buffer's write/read addresses, enables and full/empty flags. Packets are written speculatively and become readable only after their EOP beat is committed. A packet that cannot fit is rewound and discarded, and (optionally) errored packets are dropped. It sits between the ingress packet stream and the buffer, and feeds the egress word reader.

## Interface
Parameters:
- ADDR_WIDTH, 14: buffer address width; pointers are ADDR_WIDTH+1 bits (MSB = wrap bit).
- DEPTH, 16384: buffer depth; must equal 2**ADDR_WIDTH.
- DROP_CNT_W, 16: width of the drop counter.

Ports:
- pkt_buf_ctrl_clk  in  1  single clock.
- pkt_buf_ctrl_rst  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  ingress beat valid.
- wr_sop_i  in  1  first beat of packet.
- wr_eop_i  in  1  last beat of packet.
- wr_err_i  in  1  packet error; sampled only on the EOP beat.
- wr_ready_o  out  1  controller accepts the beat (valid && ready = accepted).
- rd_req_i  in  1  egress requests one word.
- rd_valid_o  out  1  buffer read data valid this cycle.
- buf_wr_en_o  out  1  buffer write enable.
- buf_wr_addr_o  out  ADDR_WIDTH+1  buffer write address, equal to wr_ptr.
- buf_rd_en_o  out  1  buffer read enable.
- buf_rd_addr_o  out  ADDR_WIDTH+1  buffer read address, equal to rd_ptr.
- buf_full_o  out  1  physical full: wr_ptr and rd_ptr differ only in the MSB.
- buf_empty_o  out  1  no committed data: rd_ptr == commit_ptr.
- words_avail_o  out  ADDR_WIDTH+1  committed unread words (commit_ptr − rd_ptr, modulo 2**(ADDR_WIDTH+1)).
- drop_cnt_o  out  DROP_CNT_W  dropped-packet count; saturates at all-ones.

## Operation
Pointers:
- wr_ptr, commit_ptr and rd_ptr are all registered.
- All arithmetic is modulo 2**(ADDR_WIDTH+1); pointers wrap naturally.

Write FSM states: IDLE, WR_PKT, DISCARD.
- **wr_ready_o** = (state==DISCARD) || !buf_full_o.
- **buf_wr_en_o** = wr_valid_i && wr_ready_o && writing beat, where "writing beat" is IDLE with wr_sop_i, or WR_PKT. No write is issued in DISCARD, and IDLE beats without SOP are not written.
- **IDLE:**
  - Beat without SOP: accepted and discarded; no count.
  - SOP beat: written at wr_ptr; wr_ptr+1; go to WR_PKT.
  - SOP+EOP on the same beat: single-word packet; commits immediately and stays in IDLE.
- **WR_PKT:**
  - Each accepted beat is written and wr_ptr+1.
  - EOP beat: commit_ptr <= wr_ptr+1; go to IDLE.
  - SOP beat before EOP: the partial packet is dropped (wr_ptr rewound to commit_ptr, drop_cnt+1). The new beat is written at commit_ptr, and the FSM stays in WR_PKT.
- **Overflow:** in WR_PKT with buf_full_o=1 and buf_empty_o=1, the open packet fills the whole buffer. In that case:
  - wr_ptr <= commit_ptr and drop_cnt+1.
  - Go to DISCARD.
  - If full with committed data still present, backpressure instead (ready=0).
- **DISCARD:** all beats are accepted and discarded. The EOP beat returns the FSM to IDLE. An SOP beat is handled as in IDLE.

Read side:
- **buf_rd_en_o** = rd_req_i && !buf_empty_o (combinational).
- On each read, rd_ptr+1. rd_valid_o is registered from buf_rd_en_o.
- rd_req_i while empty is ignored.

## Timing
- Buffer read latency is 1 cycle, so rd_valid_o aligns with buffer data.
- A committed EOP is visible (buf_empty_o=0, words_avail_o updated) in the cycle after the EOP beat.
- Full and empty come from registered pointers:
  - A read in the same cycle does not unblock a write while full.
  - A commit in the same cycle does not enable a read.
- Reset values:
  - FSM = IDLE.
  - All pointers = 0.
  - wr_ready_o=1, buf_full_o=0, buf_empty_o=1.
  - rd_valid_o, buf_wr_en_o, buf_rd_en_o = 0.
  - words_avail_o=0, drop_cnt_o=0.
- Reset mid-packet discards the partial packet silently (no drop count).
- Simultaneous commit and read in one cycle: words_avail_o = old value + packet length − 1.

## Configuration
Macro PKT_BUF_CTRL_ERR_DROP_EN:
- **Defined:** an EOP beat with wr_err_i=1 is not committed. wr_ptr <= commit_ptr, drop_cnt+1, go to IDLE; the EOP beat itself is not written.
- **Undefined:** wr_err_i is ignored and errored packets commit normally.

## Test plan
- Reset, then a 4-beat packet (SOP..EOP): buf_wr_addr_o is 0..3 and the FSM returns to IDLE. The next cycle shows words_avail_o=4 and buf_empty_o=0. Four rd_req_i give rd_valid_o for 4 cycles and rd_ptr=4, then buf_empty_o=1.
- Packets totalling DEPTH words without reads: after the last word, buf_full_o=1 and wr_ready_o=0. One read deasserts full the next cycle, and the ptr MSB toggles on wrap.
- Single packet longer than DEPTH: after DEPTH words, drop_cnt_o=1 and wr_ptr=0. The rest is accepted through EOP with no writes; a following 2-beat packet then commits at addresses 0..1.
- SOP arrives mid-packet after 3 beats: drop_cnt_o=1, and the new packet starts at commit_ptr and commits intact.
- With PKT_BUF_CTRL_ERR_DROP_EN, a 5-beat packet with wr_err_i=1 on EOP: words_avail_o stays 0, drop_cnt_o=1, wr_ptr is restored. Without the macro, words_avail_o=5.
- Reset asserted mid-packet after 2 beats: all pointers=0, buf_empty_o=1, drop_cnt_o=0.
